// File: rtl/time_counter_pkg.sv
// ----------------------------------------------------------------------------
// time_counter_pkg
// Shared constants for the time counter: direction and field-select encodings,
// the fixed seconds/minutes moduli, and a helper that sizes a register to
// hold the range 0..modulus-1.
// ----------------------------------------------------------------------------
package time_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic FIELD_HR  = 1'b0;
    localparam logic FIELD_MIN = 1'b1;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    // Bits needed for values 0..modulus-1 (never less than one bit).
    function automatic int width_for(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/time_counter_gen2_if.sv
// ----------------------------------------------------------------------------
// time_counter_gen2_if
// Control and value bundle of the time counter.
//   master: drives tick/enable/down/clear/setting_enable/set_hr_or_min/
//           inc_short/inc_long, observes the value and pulse outputs.
//   slave : the counter itself.
// Value outputs are OUT_W wide; pulses are one clk wide; at_zero is a level.
// ----------------------------------------------------------------------------
interface time_counter_gen2_if #(
    parameter int OUT_W = 14
);
    logic             tick;
    logic             enable;
    logic             down;
    logic             clear;
    logic             setting_enable;
    logic             set_hr_or_min;
    logic             inc_short;
    logic             inc_long;
    logic [OUT_W-1:0] small_sec_out;
    logic [OUT_W-1:0] seconds_out;
    logic [OUT_W-1:0] minutes_out;
    logic [OUT_W-1:0] hours_out;
    logic             sec_pulse;
    logic             day_wrap;
    logic             zero_reached;
    logic             at_zero;

    modport master (
        output tick, enable, down, clear, setting_enable, set_hr_or_min,
               inc_short, inc_long,
        input  small_sec_out, seconds_out, minutes_out, hours_out,
               sec_pulse, day_wrap, zero_reached, at_zero
    );

    modport slave (
        input  tick, enable, down, clear, setting_enable, set_hr_or_min,
               inc_short, inc_long,
        output small_sec_out, seconds_out, minutes_out, hours_out,
               sec_pulse, day_wrap, zero_reached, at_zero
    );
endinterface

// File: rtl/mod_field_counter.sv
// ----------------------------------------------------------------------------
// mod_field_counter
// One modulo-MOD digit of the cascaded time counter.
//   clk, reset   : clock, asynchronous active-high reset
//   clr          : synchronous zero, wins over every step
//   step_up      : +1, wrapping MOD-1 -> 0 and raising wrap
//   step_dn      : -1, wrapping 0 -> MOD-1 and raising wrap
//   step_nowrap  : +1 with field wrap but without signalling wrap (setting)
//   value        : registered field value
//   wrap         : combinational carry (when stepping up) or borrow (down)
// ----------------------------------------------------------------------------
module mod_field_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         step_up,
    input  logic         step_dn,
    input  logic         step_nowrap,
    output logic [W-1:0] value,
    output logic         wrap
);
    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0] value_reg;
    logic [W-1:0] value_next;
    logic         at_max;
    logic         at_min;

    assign at_max = (value_reg == MAX_VAL);
    assign at_min = (value_reg == '0);

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = '0;
        end else if (step_up || step_nowrap) begin
            value_next = at_max ? '0 : value_reg + W'(1);
        end else if (step_dn) begin
            value_next = at_min ? MAX_VAL : value_reg - W'(1);
        end
    end

    // Up and down steps are never requested together, so one wrap output
    // serves as carry or borrow depending on the caller's direction.
    assign wrap  = ~clr & ((step_up & at_max) | (step_dn & at_min));
    assign value = value_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end
endmodule

// File: rtl/time_counter_gen2.sv
// ----------------------------------------------------------------------------
// time_counter_gen2
// Cascaded sub-second/second/minute/hour counter, counting up or down, with
// in-place hour/minute setting (short-press step, long-press auto-repeat).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : time_counter_gen2_if.slave (controls in, values/pulses out)
// Priority per edge: clear > setting > counting.
// ----------------------------------------------------------------------------
module time_counter_gen2
    import time_counter_pkg::*;
#(
    parameter int TICK_HZ       = 10000,
    parameter int HOURS         = 24,
    parameter int OUT_W         = 14,
    parameter int REPEAT_DELAY  = 5000,
    parameter int REPEAT_PERIOD = 2000
) (
    input  logic               clk,
    input  logic               reset,
    time_counter_gen2_if.slave bus
);
    localparam int SUB_W   = width_for(TICK_HZ);
    localparam int SEC_W   = width_for(SEC_MOD);
    localparam int MIN_W   = width_for(MIN_MOD);
    localparam int HR_W    = width_for(HOURS);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = width_for(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [SUB_W-1:0] sub_val;
    logic [SEC_W-1:0] sec_val;
    logic [MIN_W-1:0] min_val;
    logic [HR_W-1:0]  hr_val;
    logic             sub_wrap, sec_wrap, min_wrap, hr_wrap;

    logic             count_step, up_step, dn_step;
    logic             all_zero, one_left;
    logic             set_inc, set_min, set_hr, short_edge;

    logic             inc_short_d_reg;
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic             rep_armed_reg, rep_armed_next;
    logic             rep_hold, rep_fire;

    logic             sec_pulse_reg, sec_pulse_next;
    logic             day_wrap_reg, day_wrap_next;
    logic             zero_reached_reg, zero_reached_next;

    assign all_zero   = (sub_val == '0) && (sec_val == '0) && (min_val == '0) && (hr_val == '0);
    // Exactly one sub-tick above zero; with a 1 Hz tick the sub field is
    // stuck at 0 and the last step comes from the seconds field.
    assign one_left   = (TICK_HZ > 1)
                      ? ((sub_val == SUB_W'(1)) && (sec_val == '0) && (min_val == '0) && (hr_val == '0))
                      : ((sec_val == SEC_W'(1)) && (min_val == '0) && (hr_val == '0));

    assign count_step = bus.tick & bus.enable & ~bus.setting_enable & ~bus.clear;
    assign up_step    = count_step & (bus.down == DIR_UP);
    // Counting down from all-zero is a no-op: no wrap, no pulses.
    assign dn_step    = count_step & (bus.down == DIR_DOWN) & ~all_zero;

    // inc_short step request: rising edge against last cycle's level.
    assign short_edge = bus.inc_short & ~inc_short_d_reg;

    // Auto-repeat: counts ticks while inc_long is held in setting mode. The
    // first firing waits REPEAT_DELAY ticks; afterwards the armed flag
    // switches the terminal count to REPEAT_PERIOD.
    assign rep_hold = bus.setting_enable & bus.inc_long & ~bus.clear;

    always_comb begin
        rep_cnt_next   = rep_cnt_reg;
        rep_armed_next = rep_armed_reg;
        rep_fire       = 1'b0;
        if (!rep_hold) begin
            rep_cnt_next   = '0;
            rep_armed_next = 1'b0;
        end else if (bus.tick) begin
            if ((!rep_armed_reg && rep_cnt_reg == DELAY_LAST) ||
                ( rep_armed_reg && rep_cnt_reg == PERIOD_LAST)) begin
                rep_fire       = 1'b1;
                rep_cnt_next   = '0;
                rep_armed_next = 1'b1;
            end else begin
                rep_cnt_next   = rep_cnt_reg + REP_W'(1);
            end
        end
    end

    // A short edge and a repeat firing on the same edge merge into one step.
    assign set_inc = bus.setting_enable & ~bus.clear & (short_edge | rep_fire);
    assign set_min = set_inc & (bus.set_hr_or_min == FIELD_MIN);
    assign set_hr  = set_inc & (bus.set_hr_or_min == FIELD_HR);

    mod_field_counter #(.MOD(TICK_HZ), .W(SUB_W)) u_sub (
        .clk(clk), .reset(reset), .clr(bus.clear | set_inc),
        .step_up(up_step), .step_dn(dn_step), .step_nowrap(1'b0),
        .value(sub_val), .wrap(sub_wrap)
    );

    mod_field_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk(clk), .reset(reset), .clr(bus.clear | set_inc),
        .step_up(sub_wrap & up_step), .step_dn(sub_wrap & dn_step), .step_nowrap(1'b0),
        .value(sec_val), .wrap(sec_wrap)
    );

    mod_field_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk(clk), .reset(reset), .clr(bus.clear),
        .step_up(sec_wrap & up_step), .step_dn(sec_wrap & dn_step), .step_nowrap(set_min),
        .value(min_val), .wrap(min_wrap)
    );

    mod_field_counter #(.MOD(HOURS), .W(HR_W)) u_hr (
        .clk(clk), .reset(reset), .clr(bus.clear),
        .step_up(min_wrap & up_step), .step_dn(min_wrap & dn_step), .step_nowrap(set_hr),
        .value(hr_val), .wrap(hr_wrap)
    );

    // Pulses are registered so they line up with the updated field values.
    assign sec_pulse_next    = sub_wrap;
    assign day_wrap_next     = hr_wrap & up_step;
    assign zero_reached_next = dn_step & one_left;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_short_d_reg  <= 1'b0;
            rep_cnt_reg      <= '0;
            rep_armed_reg    <= 1'b0;
            sec_pulse_reg    <= 1'b0;
            day_wrap_reg     <= 1'b0;
            zero_reached_reg <= 1'b0;
        end else begin
            inc_short_d_reg  <= bus.inc_short;
            rep_cnt_reg      <= rep_cnt_next;
            rep_armed_reg    <= rep_armed_next;
            sec_pulse_reg    <= sec_pulse_next;
            day_wrap_reg     <= day_wrap_next;
            zero_reached_reg <= zero_reached_next;
        end
    end

    assign bus.small_sec_out = OUT_W'(sub_val);
    assign bus.seconds_out   = OUT_W'(sec_val);
    assign bus.minutes_out   = OUT_W'(min_val);
    assign bus.hours_out     = OUT_W'(hr_val);
    assign bus.sec_pulse     = sec_pulse_reg;
    assign bus.day_wrap      = day_wrap_reg;
    assign bus.zero_reached  = zero_reached_reg;
    assign bus.at_zero       = all_zero;
endmodule

// File: tb/tb_time_counter_gen2.sv
// ----------------------------------------------------------------------------
// tb_time_counter_gen2
// Drives time_counter_gen2 (TICK_HZ=10, HOURS=24, repeat 5/2). The reference
// model keeps the time as one integer count of sub-ticks since midnight; each
// driven cycle pushes the expected outputs, and a negedge monitor pops and
// compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_time_counter_gen2;
    localparam int TICK_HZ = 10;
    localparam int HOURS   = 24;
    localparam int OUT_W   = 14;
    localparam int RDELAY  = 5;
    localparam int RPERIOD = 2;
    localparam int DAY     = HOURS * 3600 * TICK_HZ;

    typedef struct {
        int sub, sec, min, hr;
        bit sp, dw, zr, az;
    } exp_t;

    logic clk;
    logic reset;
    time_counter_gen2_if #(.OUT_W(OUT_W)) bif ();

    time_counter_gen2 #(
        .TICK_HZ(TICK_HZ), .HOURS(HOURS), .OUT_W(OUT_W),
        .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    // Reference model state: time in sub-ticks, held-tick count, last short level.
    int m_t = 0;
    int m_rep = 0;
    bit m_prev_short = 0;
    bit m_sp = 0, m_dw = 0, m_zr = 0;

    function automatic exp_t cur_exp();
        exp_t e;
        e.sub = m_t % TICK_HZ;
        e.sec = (m_t / TICK_HZ) % 60;
        e.min = (m_t / (60 * TICK_HZ)) % 60;
        e.hr  = m_t / (3600 * TICK_HZ);
        e.sp  = m_sp;
        e.dw  = m_dw;
        e.zr  = m_zr;
        e.az  = (m_t == 0);
        return e;
    endfunction

    task automatic model_reset();
        m_t = 0; m_rep = 0; m_prev_short = 0;
        m_sp = 0; m_dw = 0; m_zr = 0;
    endtask

    task automatic model_step(input bit tk, en, dn, clr, st, sel, sh, lg);
        bit edge_s, fire;
        int h, m;
        edge_s = sh && !m_prev_short;
        m_prev_short = sh;
        m_sp = 0; m_dw = 0; m_zr = 0;
        if (clr) begin
            m_t = 0;
            m_rep = 0;
        end else if (st) begin
            fire = 0;
            if (lg) begin
                if (tk) begin
                    m_rep++;
                    if (m_rep == RDELAY || (m_rep > RDELAY && (m_rep - RDELAY) % RPERIOD == 0))
                        fire = 1;
                end
            end else begin
                m_rep = 0;
            end
            if (edge_s || fire) begin
                h = m_t / (3600 * TICK_HZ);
                m = (m_t / (60 * TICK_HZ)) % 60;
                if (sel) m = (m + 1) % 60;
                else     h = (h + 1) % HOURS;
                m_t = (h * 60 + m) * 60 * TICK_HZ;
            end
        end else begin
            m_rep = 0;
            if (tk && en) begin
                if (!dn) begin
                    m_t  = (m_t + 1) % DAY;
                    m_sp = (m_t % TICK_HZ) == 0;
                    m_dw = (m_t == 0);
                end else if (m_t > 0) begin
                    m_sp = (m_t % TICK_HZ) == 0;
                    m_t  = m_t - 1;
                    m_zr = (m_t == 0);
                end
            end
        end
    endtask

    task automatic drive(input bit tk, en, dn, clr, st, sel, sh, lg);
        bif.tick = tk; bif.enable = en; bif.down = dn; bif.clear = clr;
        bif.setting_enable = st; bif.set_hr_or_min = sel;
        bif.inc_short = sh; bif.inc_long = lg;
        @(posedge clk);
        model_step(tk, en, dn, clr, st, sel, sh, lg);
        exp_q.push_back(cur_exp());
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    // Monitor: the DUT presents a new output set every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int a_sub, a_sec, a_min, a_hr;
            e = exp_q.pop_front();
            a_sub = int'(bif.small_sec_out); a_sec = int'(bif.seconds_out);
            a_min = int'(bif.minutes_out);   a_hr  = int'(bif.hours_out);
            n_cmp++;
            if (a_sub != e.sub || a_sec != e.sec || a_min != e.min || a_hr != e.hr ||
                bif.sec_pulse != e.sp || bif.day_wrap != e.dw ||
                bif.zero_reached != e.zr || bif.at_zero != e.az) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got %0d:%0d:%0d.%0d sp=%b dw=%b zr=%b az=%b, expected %0d:%0d:%0d.%0d sp=%b dw=%b zr=%b az=%b",
                         $time, a_hr, a_min, a_sec, a_sub, bif.sec_pulse, bif.day_wrap,
                         bif.zero_reached, bif.at_zero, e.hr, e.min, e.sec, e.sub,
                         e.sp, e.dw, e.zr, e.az);
            end else begin
                $display("[%0t] %0d:%0d:%0d.%0d sp=%b dw=%b zr=%b az=%b", $time,
                         a_hr, a_min, a_sec, a_sub, bif.sec_pulse, bif.day_wrap,
                         bif.zero_reached, bif.at_zero);
            end
        end
    end

    initial begin
        bit dn_r, st_r, lg_r;
        reset = 1'b1;
        bif.tick = 0; bif.enable = 0; bif.down = 0; bif.clear = 0;
        bif.setting_enable = 0; bif.set_hr_or_min = 0; bif.inc_short = 0; bif.inc_long = 0;
        #7;
        chk("reset_sub", int'(bif.small_sec_out), 0);
        chk("reset_hours", int'(bif.hours_out), 0);
        chk("reset_at_zero", int'(bif.at_zero), 1);
        chk("reset_pulses", int'({bif.sec_pulse, bif.day_wrap, bif.zero_reached}), 0);
        #1 reset = 1'b0;
        model_reset();

        // Up 10 ticks -> 00:00:01.0
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("up10_seconds", int'(bif.seconds_out), 1);
        chk("up10_sub", int'(bif.small_sec_out), 0);
        chk("up10_sec_pulse", int'(bif.sec_pulse), 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        chk("sec_pulse_one_clk", int'(bif.sec_pulse), 0);

        // Preset 23:59:59.9, then wrap the day
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 23; i++) begin
            drive(0, 0, 0, 0, 1, 0, 1, 0);
            drive(0, 0, 0, 0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 59; i++) begin
            drive(0, 0, 0, 0, 1, 1, 1, 0);
            drive(0, 0, 0, 0, 1, 1, 0, 0);
        end
        for (int i = 0; i < 599; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("preset_hours", int'(bif.hours_out), 23);
        chk("preset_sub", int'(bif.small_sec_out), 9);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap_day_wrap", int'(bif.day_wrap), 1);
        chk("wrap_at_zero", int'(bif.at_zero), 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        chk("day_wrap_one_clk", int'(bif.day_wrap), 0);

        // Countdown from 00:00:01.0
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 1, 0, 0, 0, 0, 0);
        chk("down_zero_reached", int'(bif.zero_reached), 1);
        chk("down_at_zero", int'(bif.at_zero), 1);
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 0, 0, 0, 0, 0);
        chk("down_stays_zero", int'(bif.at_zero), 1);
        chk("down_no_pulses", int'({bif.sec_pulse, bif.day_wrap, bif.zero_reached}), 0);

        // Setting: hours=5, minutes=59, run a bit, then step minutes 59->0
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 1, 0);
            drive(0, 0, 0, 0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 59; i++) begin
            drive(0, 0, 0, 0, 1, 1, 1, 0);
            drive(0, 0, 0, 0, 1, 1, 0, 0);
        end
        for (int i = 0; i < 37; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 0);
        chk("set_min_wrap", int'(bif.minutes_out), 0);
        chk("set_min_hours_kept", int'(bif.hours_out), 5);
        chk("set_min_sec_zero", int'(bif.seconds_out), 0);
        chk("set_min_sub_zero", int'(bif.small_sec_out), 0);
        for (int i = 0; i < 20; i++) drive(i % 2 == 0, 0, 0, 0, 1, 1, 1, 0);
        chk("held_short_single", int'(bif.minutes_out), 0);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 0);
        chk("second_press", int'(bif.minutes_out), 1);
        drive(0, 0, 0, 0, 1, 1, 0, 0);

        // Auto-repeat on hours from 0: 11 ticks -> 4 increments
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0, 1);
            drive(0, 0, 0, 0, 1, 0, 0, 1);
        end
        chk("repeat_hours", int'(bif.hours_out), 4);
        for (int i = 0; i < 10; i++) drive(i % 2 == 0, 0, 0, 0, 1, 0, 0, 0);
        chk("repeat_released", int'(bif.hours_out), 4);

        // Clear coinciding with a tick that would wrap the sub field
        for (int i = 0; i < 9; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        chk("clear_at_zero", int'(bif.at_zero), 1);
        chk("clear_no_pulse", int'(bif.sec_pulse), 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 15; i++) drive(1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("async_reset_sub", int'(bif.small_sec_out), 0);
        chk("async_reset_sec", int'(bif.seconds_out), 0);
        chk("async_reset_at_zero", int'(bif.at_zero), 1);
        model_reset();
        #1 reset = 1'b0;

        // Randomized traffic against the model
        dn_r = 0; st_r = 0; lg_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0)  dn_r = ~dn_r;
            if ($urandom_range(149) == 0) st_r = ~st_r;
            if ($urandom_range(29) == 0)  lg_r = ~lg_r;
            drive($urandom_range(1) == 1, $urandom_range(7) != 0, dn_r,
                  $urandom_range(199) == 0, st_r, $urandom_range(1) == 1,
                  $urandom_range(5) == 0, lg_r);
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
